branch_redirect_ctrl: RTL and testbench

Consumer of the per-slot `bne` mispredict flags produced by the 4-wide branch compare stage. The pipeline predicts every branch not-taken. When any slot reports a mispredict, this block performs four actions:
- selects the oldest mispredicting slot;
- issues a one-cycle redirect of fetch to that branch's target;
- kills the younger slots of the same issue group;
- holds the front end in a timed flush while wrong-path instructions drain.

It also keeps a saturating mispredict counter for performance monitoring.

---
 rtl/branch_redirect_ctrl.sv | 101 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch mispredict redirect controller: selects the oldest mispredicting slot,
// pulses a fetch redirect and kill mask, then holds a timed front-end flush.
module branch_redirect_ctrl #(
  parameter int data_width   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  bne1,
  input  logic                  bne2,
  input  logic                  bne3,
  input  logic                  bne4,
  input  logic [data_width-1:0] ins1_target,
  input  logic [data_width-1:0] ins2_target,
  input  logic [data_width-1:0] ins3_target,
  input  logic [data_width-1:0] ins4_target,
  output logic                  redirect_valid,
  output logic [data_width-1:0] redirect_pc,
  output logic [3:0]            kill_mask,
  output logic                  flush_front,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state, state_n;
  logic [3:0]            fcnt, fcnt_n;
  logic                  redirect_valid_n;
  logic [data_width-1:0] redirect_pc_n;
  logic [3:0]            kill_mask_n;
  logic [CNT_WIDTH-1:0]  count_n;
  logic                  accept;

  assign accept = (state == IDLE) && !stall && (bne1 || bne2 || bne3 || bne4);

  always_comb begin
    state_n          = state;
    fcnt_n           = fcnt;
    redirect_valid_n = 1'b0;
    redirect_pc_n    = redirect_pc;
    kill_mask_n      = '0;
    count_n          = mispredict_count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n          = FLUSH;
          fcnt_n           = 4'(FLUSH_CYCLES - 1);
          redirect_valid_n = 1'b1;
          if (mispredict_count != '1)
            count_n = mispredict_count + CNT_WIDTH'(1);
          // Oldest slot wins; flags of younger slots are wrong-path and dropped.
          if (bne1) begin
            redirect_pc_n = ins1_target;
            kill_mask_n   = 4'b1110;
          end else if (bne2) begin
            redirect_pc_n = ins2_target;
            kill_mask_n   = 4'b1100;
          end else if (bne3) begin
            redirect_pc_n = ins3_target;
            kill_mask_n   = 4'b1000;
          end else begin
            redirect_pc_n = ins4_target;
            kill_mask_n   = 4'b0000;
          end
        end
      end
      FLUSH: begin
        if (fcnt == 4'd0)
          state_n = IDLE;
        else
          fcnt_n = fcnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      fcnt             <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      kill_mask        <= '0;
      mispredict_count <= '0;
    end else begin
      state            <= state_n;
      fcnt             <= fcnt_n;
      redirect_valid   <= redirect_valid_n;
      redirect_pc      <= redirect_pc_n;
      kill_mask        <= kill_mask_n;
      mispredict_count <= count_n;
    end
  end

  assign flush_front = (state == FLUSH);
  assign busy        = (state == FLUSH);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl; a second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        bne1, bne2, bne3, bne4;
  logic [31:0] t1, t2, t3, t4;
  logic        rv, ff, bsy;
  logic [31:0] pc;
  logic [3:0]  km;
  logic [15:0] cnt;
  logic        rv_s, ff_s, bsy_s;
  logic [31:0] pc_s;
  logic [3:0]  km_s;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.data_width(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .bne1(bne1), .bne2(bne2), .bne3(bne3), .bne4(bne4),
    .ins1_target(t1), .ins2_target(t2), .ins3_target(t3), .ins4_target(t4),
    .redirect_valid(rv), .redirect_pc(pc), .kill_mask(km),
    .flush_front(ff), .busy(bsy), .mispredict_count(cnt)
  );

  branch_redirect_ctrl #(.data_width(32), .FLUSH_CYCLES(2), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall),
    .bne1(bne1), .bne2(bne2), .bne3(bne3), .bne4(bne4),
    .ins1_target(t1), .ins2_target(t2), .ins3_target(t3), .ins4_target(t4),
    .redirect_valid(rv_s), .redirect_pc(pc_s), .kill_mask(km_s),
    .flush_front(ff_s), .busy(bsy_s), .mispredict_count(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    bne1 = 1'b0; bne2 = 1'b0; bne3 = 1'b0; bne4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    clear_flags();
    t1 = '0; t2 = '0; t3 = '0; t4 = '0;
    step(); step();
    check("rst_rv", 32'(rv), 0);
    check("rst_pc", pc, 0);
    check("rst_km", 32'(km), 0);
    check("rst_ff", 32'(ff), 0);
    check("rst_busy", 32'(bsy), 0);
    check("rst_cnt", 32'(cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_rv", 32'(rv), 0);
      check("idle_ff", 32'(ff), 0);
      check("idle_cnt", 32'(cnt), 0);
    end

    // single mispredict on slot 3
    bne3 = 1'b1; t3 = 32'h400;
    step(); clear_flags();
    check("s3_rv", 32'(rv), 1);
    check("s3_pc", pc, 32'h400);
    check("s3_km", 32'(km), 32'b1000);
    check("s3_ff1", 32'(ff), 1);
    check("s3_busy1", 32'(bsy), 1);
    check("s3_cnt", 32'(cnt), 1);
    step();
    check("s3_rv2", 32'(rv), 0);
    check("s3_km2", 32'(km), 0);
    check("s3_ff2", 32'(ff), 1);
    step();
    check("s3_ff3", 32'(ff), 0);
    check("s3_busy3", 32'(bsy), 0);

    // two flags: oldest (slot 2) wins
    bne2 = 1'b1; bne4 = 1'b1; t2 = 32'h100; t4 = 32'h200;
    step(); clear_flags();
    check("s24_rv", 32'(rv), 1);
    check("s24_pc", pc, 32'h100);
    check("s24_km", 32'(km), 32'b1100);
    check("s24_cnt", 32'(cnt), 2);
    step();
    check("s24_rv2", 32'(rv), 0);
    step();
    check("s24_rv3", 32'(rv), 0);
    check("s24_cnt3", 32'(cnt), 2);

    // flags during FLUSH ignored, accepted in first IDLE cycle
    bne1 = 1'b1; t1 = 32'h40;
    step();
    check("s1_rv", 32'(rv), 1);
    check("s1_pc", pc, 32'h40);
    check("s1_km", 32'(km), 32'b1110);
    check("s1_cnt", 32'(cnt), 3);
    t1 = 32'h80;
    step();
    check("s1_flush_ign1", 32'(rv), 0);
    step();
    check("s1_flush_ign2", 32'(rv), 0);
    check("s1_idle_ff", 32'(ff), 0);
    step(); clear_flags();
    check("s1_second_rv", 32'(rv), 1);
    check("s1_second_pc", pc, 32'h80);
    check("s1_second_km", 32'(km), 32'b1110);
    check("s1_second_cnt", 32'(cnt), 4);
    step(); step();
    check("s1_drain_ff", 32'(ff), 0);

    // stall blocks acceptance in IDLE
    stall = 1'b1; bne4 = 1'b1; t4 = 32'h300;
    step();
    check("stall_rv", 32'(rv), 0);
    check("stall_busy", 32'(bsy), 0);
    check("stall_cnt", 32'(cnt), 4);
    stall = 1'b0;
    step(); clear_flags();
    check("s4_rv", 32'(rv), 1);
    check("s4_pc", pc, 32'h300);
    check("s4_km", 32'(km), 0);
    check("s4_cnt", 32'(cnt), 5);
    // stall does not freeze the flush timer
    stall = 1'b1;
    step();
    check("stall_flush_ff", 32'(ff), 1);
    step();
    check("stall_flush_end", 32'(ff), 0);
    stall = 1'b0;

    // reset in first FLUSH cycle with flags present
    bne2 = 1'b1; t2 = 32'h500;
    step(); clear_flags();
    check("r_pre_ff", 32'(ff), 1);
    check("r_pre_cnt", 32'(cnt), 6);
    rst = 1'b1; bne1 = 1'b1;
    step(); clear_flags(); rst = 1'b0;
    check("r_ff", 32'(ff), 0);
    check("r_rv", 32'(rv), 0);
    check("r_pc", pc, 0);
    check("r_km", 32'(km), 0);
    check("r_cnt", 32'(cnt), 0);
    check("r_cnt_sat", 32'(cnt_s), 0);

    // saturation of 2-bit counter
    for (int i = 0; i < 5; i++) begin
      bne1 = 1'b1; t1 = 32'(i * 16);
      step(); clear_flags();
      check("sat_rv", 32'(rv_s), 1);
      check("sat_cnt_s", 32'(cnt_s), (i + 1 > 3) ? 3 : i + 1);
      check("sat_cnt", 32'(cnt), 32'(i + 1));
      step(); step();
    end
    check("sat_final", 32'(cnt_s), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
